// File: rtl/activation_arbiter.sv
// Round-robin arbiter sharing one fixed-latency ReLU unit among N_REQ lanes, with tag tracking and flush/drain.
// Optional build macro ACTIVATION_ARBITER_STATS_EN adds issue_cnt and stall_cnt outputs.
module activation_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ACT_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [31:0]          act_in_data,
  output logic                 act_valid_in,
  input  logic [31:0]          act_out_data,
  input  logic                 act_valid_out,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [31:0]          rsp_data,
  input  logic                 flush,
  output logic                 flush_done,
  output logic                 tag_err
`ifdef ACTIVATION_ARBITER_STATS_EN
  ,
  output logic [31:0]          issue_cnt,
  output logic [31:0]          stall_cnt
`endif
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(ACT_LAT + 2) + 1;
  localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N_REQ);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;
  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [N_REQ-1:0] rot;
  logic             grant_any;
  logic [IDX_W:0]   idx_sum;
  logic [IDX_W-1:0] grant_idx;
  logic [31:0]      grant_data;
  logic             grant_en;
  logic             xfer;
  tag_t             tag_q [ACT_LAT+1];
  tag_t             tail;
  logic [CNT_W-1:0] inflight_q;

  // Rotate requests so bit 0 is the lane at ptr; the lowest set bit wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rot       = N_REQ'({req_valid, req_valid} >> ptr_q);
    grant_any = 1'b0;
    idx_sum   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        grant_any = 1'b1;
        idx_sum   = {1'b0, ptr_q} + (IDX_W + 1)'(j);
      end
    end
    if (idx_sum >= N_W) idx_sum = idx_sum - N_W;
    grant_idx = idx_sum[IDX_W-1:0];
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) grant_data = req_data[32*i +: 32];
    end
  end

  assign grant_en  = rst_n && (state_q == ST_RUN) && !flush;
  assign xfer      = grant_en && grant_any;
  assign req_ready = xfer ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
  assign tail      = tag_q[ACT_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_valid_in <= 1'b0;
      act_in_data  <= '0;
      ptr_q        <= '0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments.
      act_valid_in <= xfer;
      if (xfer) begin
        act_in_data <= grant_data;
        ptr_q       <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the tag array is reset because its valid bits are control state, not data storage.
      for (int k = 0; k <= ACT_LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0].vld <= xfer;
      tag_q[0].idx <= grant_idx;
      for (int k = 1; k <= ACT_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // A result and its tag must line up exactly; any disagreement is a sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      tag_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (act_valid_out && tail.vld) begin
        rsp_valid <= {{(N_REQ-1){1'b0}}, 1'b1} << tail.idx;
        rsp_data  <= act_out_data;
      end
      if (act_valid_out != tail.vld) tag_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
    end else begin
      unique case ({xfer, tail.vld})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (flush) state_d = ST_DRAIN;
      ST_DRAIN: if (inflight_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  assign flush_done = (state_q == ST_DONE);

`ifdef ACTIVATION_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else if (flush_done) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (xfer) issue_cnt <= issue_cnt + 32'd1;
      if ((|req_valid) && !xfer) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_activation_arbiter.sv
// Self-checking bench for activation_arbiter: grant table, corner-case sequences and random traffic
// compared against a queue-based reference model; the bench also plays the ReLU unit.
module tb_activation_arbiter;
  localparam int N = 4;
  localparam int L = 1;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [32*N-1:0]  req_data;
  logic [N-1:0]     req_ready;
  logic [31:0]      act_in_data;
  logic             act_valid_in;
  logic [31:0]      act_out_data;
  logic             act_valid_out;
  logic [N-1:0]     rsp_valid;
  logic [31:0]      rsp_data;
  logic             flush;
  logic             flush_done;
  logic             tag_err;

  activation_arbiter #(.N_REQ(N), .ACT_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .act_in_data(act_in_data), .act_valid_in(act_valid_in),
    .act_out_data(act_out_data), .act_valid_out(act_valid_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .flush(flush), .flush_done(flush_done), .tag_err(tag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          lane;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] ready;
  } vec_t;

  // ReLU unit history: hv[j]/hd[j] = act_valid_in/act_in_data j cycles ago
  logic        hv [1:L];
  logic [31:0] hd [1:L];

  // Reference model
  int          m_ptr, m_mode, cyc;   // m_mode: 0 run, 1 drain, 2 done
  logic        m_avi, m_err;
  logic [31:0] m_aid, m_rd;
  sb_t         sb[$];

  int n_checks, n_pass;
  logic [N-1:0] last_ready, last_rv;
  logic [31:0]  last_rd;
  logic [32*N-1:0] base_data;

  function automatic logic [31:0] relu(logic [31:0] x);
    return x[31] ? 32'd0 : x;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_mode = 0; cyc = 0;
    m_avi = 1'b0; m_err = 1'b0; m_aid = '0; m_rd = '0;
    sb.delete();
    for (int j = 1; j <= L; j++) begin hv[j] = 1'b0; hd[j] = '0; end
  endtask

  // One clock cycle: apply inputs at negedge, compare, then advance the model past the posedge.
  task automatic tick(logic [N-1:0] v, logic [32*N-1:0] d, logic f, logic inj);
    logic [N-1:0] er, erv;
    logic [31:0]  erd;
    int gl, l, cnt;
    logic match;
    @(negedge clk);
    req_valid     = v;
    req_data      = d;
    flush         = f;
    act_valid_out = hv[L] | inj;
    act_out_data  = relu(hd[L]);
    #1;
    er = '0; gl = -1;
    if (m_mode == 0 && !f) begin
      for (int k = 0; k < N; k++) begin
        l = (m_ptr + k) % N;
        if (gl < 0 && v[l]) gl = l;
      end
    end
    if (gl >= 0) er[gl] = 1'b1;
    erv = '0; erd = m_rd;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      erv[sb[0].lane] = 1'b1;
      erd  = relu(sb[0].data);
      m_rd = erd;
      void'(sb.pop_front());
    end
    cnt = sb.size();
    check("req_ready",    32'(req_ready),    32'(er));
    check("act_valid_in", 32'(act_valid_in), 32'(m_avi));
    check("act_in_data",  act_in_data,       m_aid);
    check("rsp_valid",    32'(rsp_valid),    32'(erv));
    check("rsp_data",     rsp_data,          erd);
    check("flush_done",   32'(flush_done),   32'(m_mode == 2));
    check("tag_err",      32'(tag_err),      32'(m_err));
    last_ready = req_ready; last_rv = rsp_valid; last_rd = rsp_data;
    match = (sb.size() > 0 && sb[0].due == cyc + 1);
    if (act_valid_out != match) m_err = 1'b1;
    case (m_mode)
      0: if (f) m_mode = 1;
      1: if (cnt == 0) m_mode = 2;
      default: m_mode = 0;
    endcase
    if (gl >= 0) begin
      sb.push_back('{due: cyc + L + 2, lane: gl, data: d[32*gl +: 32]});
      m_ptr = (gl + 1) % N;
      m_aid = d[32*gl +: 32];
      m_avi = 1'b1;
    end else begin
      m_avi = 1'b0;
    end
    for (int j = L; j >= 2; j--) begin hv[j] = hv[j-1]; hd[j] = hd[j-1]; end
    hv[1] = act_valid_in;
    hd[1] = act_in_data;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_req_ready",    32'(req_ready),    32'd0);
    check("rst_act_valid_in", 32'(act_valid_in), 32'd0);
    check("rst_act_in_data",  act_in_data,       32'd0);
    check("rst_rsp_valid",    32'(rsp_valid),    32'd0);
    check("rst_rsp_data",     rsp_data,          32'd0);
    check("rst_flush_done",   32'(flush_done),   32'd0);
    check("rst_tag_err",      32'(tag_err),      32'd0);
    req_valid = '0; flush = 1'b0; act_valid_out = 1'b0; act_out_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    logic [32*N-1:0] d;
    logic [31:0] w;
    int seen;

    tbl[0]  = '{4'b0000, 4'b0000};
    tbl[1]  = '{4'b1111, 4'b0001};
    tbl[2]  = '{4'b1111, 4'b0010};
    tbl[3]  = '{4'b1111, 4'b0100};
    tbl[4]  = '{4'b1111, 4'b1000};
    tbl[5]  = '{4'b1111, 4'b0001};
    tbl[6]  = '{4'b0001, 4'b0001};
    tbl[7]  = '{4'b0000, 4'b0000};
    tbl[8]  = '{4'b1010, 4'b0010};
    tbl[9]  = '{4'b1010, 4'b1000};
    tbl[10] = '{4'b1010, 4'b0010};
    tbl[11] = '{4'b1010, 4'b1000};
    tbl[12] = '{4'b0100, 4'b0100};
    tbl[13] = '{4'b0011, 4'b0001};

    n_checks = 0; n_pass = 0;
    rst_n = 1'b0; req_valid = '0; req_data = '0; flush = 1'b0;
    act_valid_out = 1'b0; act_out_data = '0;
    for (int i = 0; i < N; i++) base_data[32*i +: 32] = 32'h10 + 32'(i);
    model_reset();
    do_reset();

    // Grant order from ptr=0: fairness, wrap-around and sparse lanes
    for (int i = 0; i < 14; i++) begin
      tick(tbl[i].valid, base_data, 1'b0, 1'b0);
      check("tbl_grant", 32'(last_ready), 32'(tbl[i].ready));
    end
    repeat (4) tick('0, base_data, 1'b0, 1'b0);

    // Negative word on lane 2 returns zero three cycles later
    d = base_data;
    d[32*2 +: 32] = 32'hFFFF_FFF0;
    tick(4'b0100, d, 1'b0, 1'b0);
    repeat (3) tick('0, d, 1'b0, 1'b0);
    check("neg_rsp_valid", 32'(last_rv), 32'h4);
    check("neg_rsp_data",  last_rd,      32'h0);

    // Flush with two words in flight; grants must resume right after flush_done
    tick(4'b1111, base_data, 1'b0, 1'b0);
    tick(4'b1111, base_data, 1'b0, 1'b0);
    tick(4'b1111, base_data, 1'b1, 1'b0);
    seen = 0;
    for (int i = 0; i < 12 && seen == 0; i++) begin
      tick(4'b1111, base_data, 1'b0, 1'b0);
      if (flush_done) seen = i + 1;
    end
    check("flush_done_seen", 32'(seen != 0), 32'd1);
    check("flush_done_delay", 32'(seen), 32'(L + 2));
    tick(4'b1111, base_data, 1'b0, 1'b0);
    check("grant_after_flush", 32'(last_ready != '0), 32'd1);
    repeat (4) tick('0, base_data, 1'b0, 1'b0);

    // Unmatched result: sticky tag_err, no response, cleared by reset
    tick('0, base_data, 1'b0, 1'b1);
    repeat (3) tick('0, base_data, 1'b0, 1'b0);
    check("tag_err_sticky", 32'(tag_err), 32'd1);
    check("tag_err_no_rsp", 32'(last_rv), 32'd0);
    do_reset();
    tick('0, base_data, 1'b0, 1'b0);

    // Reset with words in flight
    repeat (3) tick(4'b1111, base_data, 1'b0, 1'b0);
    req_valid = 4'b1111;
    do_reset();
    repeat (4) tick('0, base_data, 1'b0, 1'b0);
    tick(4'b1111, base_data, 1'b0, 1'b0);
    check("ptr_after_reset", 32'(last_ready), 32'h1);
    repeat (4) tick('0, base_data, 1'b0, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < N; k++) begin
        w = $urandom;
        d[32*k +: 32] = w;
      end
      tick(N'($urandom_range(0, (1 << N) - 1)), d, ($urandom_range(0, 19) == 0), 1'b0);
    end
    repeat (8) tick('0, base_data, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/activation_arbiter.md
# activation_arbiter

Round-robin arbiter that shares one ReLU activation unit among `N_REQ` processing-element lanes. Each lane offers a 32-bit accumulator result; the arbiter grants one lane per cycle, issues the word to the activation unit, and tracks the lane tag through the unit's fixed latency. It returns each activated result to its originating lane, and provides a flush sequence for layer boundaries. It sits between the PE array outputs and the activation stage in the inference pipeline.

## Interface
- `N_REQ`, 4: number of requesting lanes, 2..8.
- `ACT_LAT`, 1: activation unit latency in cycles, valid-in to valid-out, 1..4.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in `N_REQ`: lane i has a word.
- `req_data` in `32*N_REQ`: lane i word at bits [32i+31:32i].
- `req_ready` out `N_REQ`: one-hot grant, combinational. Transfer occurs when `req_valid[i] & req_ready[i]`.
- `act_in_data` out 32: word to the activation unit.
- `act_valid_in` out 1: issue strobe to the activation unit.
- `act_out_data` in 32: result from the activation unit.
- `act_valid_out` in 1: result strobe from the activation unit.
- `rsp_valid` out `N_REQ`: one-hot result strobe per lane. Lanes have no backpressure.
- `rsp_data` out 32: result word, shared by all lanes.
- `flush` in 1: request to stop issuing and drain in-flight words.
- `flush_done` out 1: single-cycle pulse when the drain completes.
- `tag_err` out 1: sticky error; result arrived with no matching tag.

## Operation
- **States:**
  - **RUN:** grants enabled.
  - **DRAIN:** no grants; waiting until the in-flight count reaches 0.
  - **DONE:** one cycle; pulses `flush_done`, then returns to RUN.
- **Transitions:**
  - RUN→DRAIN when `flush=1`. The cycle `flush` is sampled high still issues no grant, because `req_ready` is gated by `flush` combinationally.
  - DRAIN→DONE when the in-flight count is 0. RUN→DRAIN→DONE is taken even if nothing is in flight.
  - DONE→RUN unconditionally. `flush` held high re-enters DRAIN on the next cycle.
- **Arbitration:**
  - Round-robin pointer `ptr`, reset 0.
  - The grant goes to the first i with `req_valid[i]=1`, scanning ptr, ptr+1, … mod `N_REQ`.
  - After a transfer, `ptr` = granted index + 1 mod `N_REQ`. With no transfer, `ptr` holds.
- **Issue:** the granted word is registered into `act_in_data`, with `act_valid_in=1` the next cycle. When there is no transfer, `act_valid_in=0` and `act_in_data` holds its previous value.
- **Tag pipeline:**
  - A valid+index shift register of depth `ACT_LAT+1` is loaded on transfer.
  - On `act_valid_out`, the stage-`ACT_LAT` entry must be valid. Its index selects the `rsp_valid` bit.
  - If that entry is invalid, `tag_err` is set and no response is generated.
  - A valid tag entry without `act_valid_out` also sets `tag_err`, and the entry is dropped.
- **In-flight count:** width clog2(`ACT_LAT+2`)+1. It increments on transfer and decrements on tag retirement; both in the same cycle means no change.
- **Response:** `rsp_data` and `rsp_valid` are registered. `rsp_data` holds between strobes.
- **Reset:** every output, the pointer, the tags, the count and the state clear asynchronously. State resets to RUN. Words in flight at reset are discarded.

## Timing
- **End-to-end latency:** `ACT_LAT+2` cycles from transfer edge to `rsp_valid`; 3 cycles with the defaults.
- **Throughput:** one word per cycle sustained.
- **Fairness:** with all lanes valid, each lane is granted once every `N_REQ` cycles.
- **Reset values:**
  - `req_ready`: 0 while `rst_n=0`, otherwise combinational.
  - `act_valid_in`: 0.
  - `act_in_data`: 0.
  - `rsp_valid`: 0.
  - `rsp_data`: 0.
  - `flush_done`: 0.
  - `tag_err`: 0.
- **Drain duration:** `flush_done` asserts `ACT_LAT+3` cycles after the last transfer at most.

## Configuration
- `ACTIVATION_ARBITER_STATS_EN` defined:
  - Adds output `issue_cnt` [31:0], the total number of transfers, wrapping at 2^32.
  - Adds output `stall_cnt` [31:0], the number of cycles with any `req_valid` set but no transfer (DRAIN/DONE stalls included).
  - Both counters reset to 0 and clear on `flush_done`.
- Macro undefined: neither port nor any counter logic exists.

## Test plan
- **Fairness:** all 4 lanes hold valid with data 0x10+i, ACT_LAT=1 → grants in order 0,1,2,3,0…; each `rsp_valid[i]` appears 3 cycles after its grant with `rsp_data` 0x10+i.
- **Sparse lanes / pointer:** only lanes 1 and 3 valid, ptr=2 → grants alternate 3,1,3; lanes 0 and 2 are never asserted.
- **Negative input:** lane 2 sends 0xFFFF_FFF0 → `rsp_valid[2]` with `rsp_data`=0 at transfer+3.
- **Flush mid-burst:** flush asserted with 2 words in flight → no further `req_ready`; both responses delivered; `flush_done` pulses one cycle after the count hits 0; grants resume the next cycle.
- **Unmatched result:** inject `act_valid_out=1` with no issue → `tag_err`=1 and stays 1; `rsp_valid` stays 0; reset clears `tag_err`.
- **Reset mid-operation:** deassert `rst_n` with 3 words in flight → all outputs 0 immediately; after release, no stale `rsp_valid` and ptr=0.
